// File: rtl/enemy_sprite_addr_gen_pkg.sv
// Shared codes and per-type sprite geometry for the enemy sprite address generator.
// Latency: n/a (constants and pure combinational helper functions).
// Backpressure: n/a.
package enemy_sprite_addr_gen_pkg;

    typedef enum logic [2:0] {
        CH_NONE     = 3'd0,
        KILLER_BIRD = 3'd1,
        WHITE_BEAR  = 3'd2,
        METAL_DUCK  = 3'd3,
        BLACK_BEAR  = 3'd4
    } enemy_type_e;

    typedef enum logic [2:0] {
        ST_NONE = 3'd0,
        MOVE_0  = 3'd1,
        MOVE_1  = 3'd2,
        MOVE_2  = 3'd3,
        ATT_CD  = 3'd4,
        ATT_0   = 3'd5,
        ATT_1   = 3'd6,
        ATT_2   = 3'd7
    } enemy_state_e;

    // Largest address is 5*600 + 29*20 + 19 = 3599, so 12 bits are the minimum.
    localparam int MIN_ADDR_W = 12;

    // Sprite width in texels; 0 for types that are never drawn.
    function automatic logic [4:0] sprite_w(input logic [2:0] t);
        case (t)
            KILLER_BIRD, METAL_DUCK: return 5'd16;
            WHITE_BEAR, BLACK_BEAR:  return 5'd20;
            default:                 return 5'd0;
        endcase
    endfunction

    // Sprite height in texels.
    function automatic logic [4:0] sprite_h(input logic [2:0] t);
        case (t)
            KILLER_BIRD:            return 5'd15;
            WHITE_BEAR, BLACK_BEAR: return 5'd30;
            METAL_DUCK:             return 5'd20;
            default:                return 5'd0;
        endcase
    endfunction

    // Texels per animation frame in the type's ROM.
    function automatic logic [11:0] frame_size(input logic [2:0] t);
        case (t)
            KILLER_BIRD:            return 12'd240;
            WHITE_BEAR, BLACK_BEAR: return 12'd600;
            METAL_DUCK:             return 12'd320;
            default:                return 12'd0;
        endcase
    endfunction

    // Animation state to ROM frame index; the attack cool-down reuses frame 0.
    function automatic logic [2:0] state_frame(input logic [2:0] s);
        case (s)
            MOVE_0:  return 3'd0;
            MOVE_1:  return 3'd1;
            MOVE_2:  return 3'd2;
            ATT_CD:  return 3'd0;
            ATT_0:   return 3'd3;
            ATT_1:   return 3'd4;
            ATT_2:   return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    // Only the four real enemy types in a non-idle state are drawn.
    function automatic logic slot_visible(input logic [2:0] t, input logic [2:0] s);
        return (t >= 3'd1) && (t <= 3'd4) && (s != ST_NONE);
    endfunction

    // Frame base address: frame*FRAME_SIZE as a small shift-add table.
    function automatic logic [11:0] frame_base(input logic [2:0] t, input logic [2:0] f);
        logic [11:0] fs;
        fs = frame_size(t);
        case (f)
            3'd1:    return fs;
            3'd2:    return fs << 1;
            3'd3:    return (fs << 1) + fs;
            3'd4:    return fs << 2;
            3'd5:    return (fs << 2) + fs;
            default: return 12'd0;
        endcase
    endfunction

    // row*W for the two sprite widths in use (16 and 20), as shifts and one add.
    function automatic logic [11:0] row_offset(input logic [2:0] t, input logic [4:0] row);
        logic [11:0] r;
        r = {7'd0, row};
        case (t)
            KILLER_BIRD, METAL_DUCK: return r << 4;
            WHITE_BEAR, BLACK_BEAR:  return (r << 4) + (r << 2);
            default:                 return 12'd0;
        endcase
    endfunction

endpackage

// File: rtl/enemy_sprite_addr_gen_if.sv
// Bundle between enemy controller / VGA timing (master) and the sprite address generator (slave).
// Latency: n/a (wires only).
// Backpressure: none; the pixel stream is free-running.
interface enemy_sprite_addr_gen_if #(
    parameter int N_SLOTS = 4,
    parameter int SLOT_W  = 2,
    parameter int ADDR_W  = 12
);
    logic                    frame_start;
    logic [9:0]              h_cnt;
    logic [9:0]              v_cnt;
    logic [3*N_SLOTS-1:0]    slot_type;
    logic [3*N_SLOTS-1:0]    slot_state;
    logic [10*N_SLOTS-1:0]   slot_x;
    logic [10*N_SLOTS-1:0]   slot_y;
    logic [N_SLOTS-1:0]      slot_flip;
    logic                    pix_hit;
    logic [ADDR_W-1:0]       pix_addr;
    logic [2:0]              pix_type;
    logic [SLOT_W-1:0]       pix_slot;

    modport master (
        output frame_start, h_cnt, v_cnt,
        output slot_type, slot_state, slot_x, slot_y, slot_flip,
        input  pix_hit, pix_addr, pix_type, pix_slot
    );

    modport slave (
        input  frame_start, h_cnt, v_cnt,
        input  slot_type, slot_state, slot_x, slot_y, slot_flip,
        output pix_hit, pix_addr, pix_type, pix_slot
    );
endinterface

// File: rtl/enemy_sprite_addr_gen_slot_hit.sv
// Stage-1 hit test for one snapshot slot: box test, texel row/col with scale and mirror.
// Latency: 1 cycle, registered outputs.
// Backpressure: none; accepts a pixel every cycle.
module enemy_slot_hit
    import enemy_sprite_addr_gen_pkg::*;
#(
    parameter int SCALE_SHIFT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] snap_type,
    input  logic [2:0] snap_state,
    input  logic [9:0] snap_x,
    input  logic [9:0] snap_y,
    input  logic       snap_flip,
    input  logic [9:0] h_cnt,
    input  logic [9:0] v_cnt,
    output logic       in_box,
    output logic [4:0] row,
    output logic [4:0] col,
    output logic [2:0] frame,
    output logic [2:0] sprite_type
);

    logic [10:0] dx;
    logic [10:0] dy;
    logic [10:0] w_scaled;
    logic [10:0] h_scaled;
    logic [4:0]  w_tex;
    logic [4:0]  col_raw;
    logic [4:0]  col_out;
    logic [4:0]  row_raw;
    logic        hit_now;

    // 11-bit differences: bit 10 set means the pixel is left of / above the sprite,
    // so a sprite hanging off the right edge can never alias onto column 0.
    assign dx       = {1'b0, h_cnt} - {1'b0, snap_x};
    assign dy       = {1'b0, v_cnt} - {1'b0, snap_y};
    assign w_tex    = sprite_w(snap_type);
    assign w_scaled = {6'd0, w_tex} << SCALE_SHIFT;
    assign h_scaled = {6'd0, sprite_h(snap_type)} << SCALE_SHIFT;
    assign col_raw  = 5'(dx >> SCALE_SHIFT);
    assign row_raw  = 5'(dy >> SCALE_SHIFT);
    assign col_out  = snap_flip ? (w_tex - 5'd1 - col_raw) : col_raw;
    assign hit_now  = slot_visible(snap_type, snap_state)
                      && !dx[10] && (dx < w_scaled)
                      && !dy[10] && (dy < h_scaled);

    // Register the per-slot stage-1 result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_box      <= 1'b0;
            row         <= '0;
            col         <= '0;
            frame       <= '0;
            sprite_type <= '0;
        end else begin
            in_box      <= hit_now;
            row         <= row_raw;
            col         <= col_out;
            frame       <= state_frame(snap_state);
            sprite_type <= snap_type;
        end
    end

endmodule

// File: rtl/enemy_sprite_addr_gen.sv
// Multi-slot enemy sprite ROM address generator: frame snapshot, per-slot hit, front-slot priority.
// Latency: 2 cycles from (h_cnt, v_cnt) to pix_* outputs, every cycle.
// Backpressure: none; free-running pixel pipeline with no stalls.
module enemy_sprite_addr_gen
    import enemy_sprite_addr_gen_pkg::*;
#(
    parameter int N_SLOTS     = 4,
    parameter int SLOT_W      = 2,   // 2**SLOT_W must cover N_SLOTS
    parameter int ADDR_W      = 12,  // must be at least MIN_ADDR_W
    parameter int SCALE_SHIFT = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    enemy_sprite_addr_gen_if.slave  bus
);

    logic [2:0] snap_type  [N_SLOTS];
    logic [2:0] snap_state [N_SLOTS];
    logic [9:0] snap_x     [N_SLOTS];
    logic [9:0] snap_y     [N_SLOTS];
    logic       snap_flip  [N_SLOTS];

    logic       s1_in_box  [N_SLOTS];
    logic [4:0] s1_row     [N_SLOTS];
    logic [4:0] s1_col     [N_SLOTS];
    logic [2:0] s1_frame   [N_SLOTS];
    logic [2:0] s1_type    [N_SLOTS];

    logic              win_hit;
    logic [SLOT_W-1:0] win_idx;
    logic [4:0]        win_row;
    logic [4:0]        win_col;
    logic [2:0]        win_frame;
    logic [2:0]        win_type;
    logic [11:0]       win_addr;

    // Capture every slot once per frame so mid-frame controller updates cannot tear the picture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                snap_type[i]  <= '0;
                snap_state[i] <= '0;
                snap_x[i]     <= '0;
                snap_y[i]     <= '0;
                snap_flip[i]  <= 1'b0;
            end
        end else if (bus.frame_start) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                snap_type[i]  <= bus.slot_type[3*i +: 3];
                snap_state[i] <= bus.slot_state[3*i +: 3];
                snap_x[i]     <= bus.slot_x[10*i +: 10];
                snap_y[i]     <= bus.slot_y[10*i +: 10];
                snap_flip[i]  <= bus.slot_flip[i];
            end
        end
    end

    for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
        enemy_slot_hit #(
            .SCALE_SHIFT (SCALE_SHIFT)
        ) u_hit (
            .clk         (clk),
            .rst_n       (rst_n),
            .snap_type   (snap_type[g]),
            .snap_state  (snap_state[g]),
            .snap_x      (snap_x[g]),
            .snap_y      (snap_y[g]),
            .snap_flip   (snap_flip[g]),
            .h_cnt       (bus.h_cnt),
            .v_cnt       (bus.v_cnt),
            .in_box      (s1_in_box[g]),
            .row         (s1_row[g]),
            .col         (s1_col[g]),
            .frame       (s1_frame[g]),
            .sprite_type (s1_type[g])
        );
    end

    // Priority pick: scan from the back so the lowest-index in-box slot is written last and wins.
    always_comb begin
        win_hit   = 1'b0;
        win_idx   = '0;
        win_row   = '0;
        win_col   = '0;
        win_frame = '0;
        win_type  = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (s1_in_box[i]) begin
                win_hit   = 1'b1;
                win_idx   = SLOT_W'(i);
                win_row   = s1_row[i];
                win_col   = s1_col[i];
                win_frame = s1_frame[i];
                win_type  = s1_type[i];
            end
        end
    end

    // Address = frame base + row*W + col, all constant shift-adds per type.
    assign win_addr = frame_base(win_type, win_frame)
                    + row_offset(win_type, win_row)
                    + {7'd0, win_col};

    // Stage-2 output register; outputs are all zero whenever no slot covers the pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.pix_hit  <= 1'b0;
            bus.pix_addr <= '0;
            bus.pix_type <= '0;
            bus.pix_slot <= '0;
        end else if (win_hit) begin
            bus.pix_hit  <= 1'b1;
            bus.pix_addr <= ADDR_W'(win_addr);
            bus.pix_type <= win_type;
            bus.pix_slot <= win_idx;
        end else begin
            bus.pix_hit  <= 1'b0;
            bus.pix_addr <= '0;
            bus.pix_type <= '0;
            bus.pix_slot <= '0;
        end
    end

endmodule

// File: tb/tb_enemy_sprite_addr_gen.sv
// Directed bench for enemy_sprite_addr_gen: unscaled instance plus a SCALE_SHIFT=1 instance.
// Latency: checks land exactly two rising edges after the pixel is driven.
// Backpressure: n/a.
module tb_enemy_sprite_addr_gen;

    logic clk;
    logic rst_n;
    int   total;
    int   passed;

    enemy_sprite_addr_gen_if #(.N_SLOTS(4), .SLOT_W(2), .ADDR_W(12)) bus0 ();
    enemy_sprite_addr_gen_if #(.N_SLOTS(4), .SLOT_W(2), .ADDR_W(12)) bus1 ();

    enemy_sprite_addr_gen #(
        .N_SLOTS(4), .SLOT_W(2), .ADDR_W(12), .SCALE_SHIFT(0)
    ) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    enemy_sprite_addr_gen #(
        .N_SLOTS(4), .SLOT_W(2), .ADDR_W(12), .SCALE_SHIFT(1)
    ) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic set_slot(input int sel, input int i, input logic [2:0] t, input logic [2:0] s,
                            input logic [9:0] x, input logic [9:0] y, input logic f);
        if (sel == 0) begin
            bus0.slot_type[3*i +: 3]  = t;
            bus0.slot_state[3*i +: 3] = s;
            bus0.slot_x[10*i +: 10]   = x;
            bus0.slot_y[10*i +: 10]   = y;
            bus0.slot_flip[i]         = f;
        end else begin
            bus1.slot_type[3*i +: 3]  = t;
            bus1.slot_state[3*i +: 3] = s;
            bus1.slot_x[10*i +: 10]   = x;
            bus1.slot_y[10*i +: 10]   = y;
            bus1.slot_flip[i]         = f;
        end
    endtask

    task automatic pulse_frame(input int sel);
        @(negedge clk);
        if (sel == 0) bus0.frame_start = 1'b1;
        else          bus1.frame_start = 1'b1;
        @(negedge clk);
        bus0.frame_start = 1'b0;
        bus1.frame_start = 1'b0;
    endtask

    task automatic check_outs(input int sel, input string tag, input logic hit,
                              input logic [11:0] addr, input logic [2:0] typ, input logic [1:0] slot);
        if (sel == 0) begin
            check({tag, ".hit"},  32'(bus0.pix_hit),  32'(hit));
            check({tag, ".addr"}, 32'(bus0.pix_addr), 32'(addr));
            check({tag, ".type"}, 32'(bus0.pix_type), 32'(typ));
            check({tag, ".slot"}, 32'(bus0.pix_slot), 32'(slot));
        end else begin
            check({tag, ".hit"},  32'(bus1.pix_hit),  32'(hit));
            check({tag, ".addr"}, 32'(bus1.pix_addr), 32'(addr));
            check({tag, ".type"}, 32'(bus1.pix_type), 32'(typ));
            check({tag, ".slot"}, 32'(bus1.pix_slot), 32'(slot));
        end
    endtask

    // Drive a pixel, wait the two pipeline edges, then sample 1 ns after the second.
    task automatic pix(input int sel, input logic [9:0] h, input logic [9:0] v, input logic hit,
                       input logic [11:0] addr, input logic [2:0] typ, input logic [1:0] slot,
                       input string tag);
        @(negedge clk);
        if (sel == 0) begin bus0.h_cnt = h; bus0.v_cnt = v; end
        else          begin bus1.h_cnt = h; bus1.v_cnt = v; end
        @(posedge clk);
        @(posedge clk);
        #1;
        check_outs(sel, tag, hit, addr, typ, slot);
    endtask

    initial begin
        total  = 0;
        passed = 0;
        rst_n  = 1'b0;
        bus0.frame_start = 1'b0; bus0.h_cnt = '0; bus0.v_cnt = '0;
        bus0.slot_type = '0; bus0.slot_state = '0; bus0.slot_x = '0; bus0.slot_y = '0; bus0.slot_flip = '0;
        bus1.frame_start = 1'b0; bus1.h_cnt = '0; bus1.v_cnt = '0;
        bus1.slot_type = '0; bus1.slot_state = '0; bus1.slot_x = '0; bus1.slot_y = '0; bus1.slot_flip = '0;

        repeat (3) @(posedge clk);
        #1;
        check_outs(0, "reset", 1'b0, 12'd0, 3'd0, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Empty frame: nothing drawn anywhere.
        pulse_frame(0);
        for (int k = 0; k < 6; k++)
            pix(0, 10'(k * 100), 10'(k * 70), 1'b0, 12'd0, 3'd0, 2'd0, "empty");

        // Bird loaded but no frame_start yet: still invisible.
        set_slot(0, 0, 3'd1, 3'd2, 10'd100, 10'd200, 1'b0);
        pix(0, 10'd105, 10'd203, 1'b0, 12'd0, 3'd0, 2'd0, "pre_snap");
        pulse_frame(0);
        pix(0, 10'd105, 10'd203, 1'b1, 12'd293, 3'd1, 2'd0, "bird");
        set_slot(0, 0, 3'd1, 3'd2, 10'd100, 10'd200, 1'b1);
        pulse_frame(0);
        pix(0, 10'd105, 10'd203, 1'b1, 12'd298, 3'd1, 2'd0, "bird_flip");
        set_slot(0, 0, 3'd1, 3'd2, 10'd100, 10'd200, 1'b0);

        // White bear ATT_2: last texel of the ROM, then just outside right and bottom.
        set_slot(0, 2, 3'd2, 3'd7, 10'd300, 10'd100, 1'b0);
        pulse_frame(0);
        pix(0, 10'd319, 10'd129, 1'b1, 12'd3599, 3'd2, 2'd2, "bear_max");
        pix(0, 10'd320, 10'd129, 1'b0, 12'd0, 3'd0, 2'd0, "bear_right");
        pix(0, 10'd319, 10'd130, 1'b0, 12'd0, 3'd0, 2'd0, "bear_bottom");

        // Overlap: slot0 bird in front of slot1 black bear; then bird goes idle.
        set_slot(0, 1, 3'd4, 3'd1, 10'd90, 10'd190, 1'b0);
        pulse_frame(0);
        pix(0, 10'd105, 10'd203, 1'b1, 12'd293, 3'd1, 2'd0, "prio_front");
        set_slot(0, 0, 3'd1, 3'd0, 10'd100, 10'd200, 1'b0);
        pulse_frame(0);
        pix(0, 10'd105, 10'd203, 1'b1, 12'd275, 3'd4, 2'd1, "prio_back");

        // Mid-frame input change is ignored until the next frame_start.
        set_slot(0, 0, 3'd1, 3'd2, 10'd100, 10'd200, 1'b0);
        set_slot(0, 1, 3'd0, 3'd0, 10'd0, 10'd0, 1'b0);
        set_slot(0, 2, 3'd0, 3'd0, 10'd0, 10'd0, 1'b0);
        pulse_frame(0);
        pix(0, 10'd105, 10'd203, 1'b1, 12'd293, 3'd1, 2'd0, "snap_before");
        set_slot(0, 0, 3'd1, 3'd2, 10'd200, 10'd200, 1'b0);
        pix(0, 10'd105, 10'd203, 1'b1, 12'd293, 3'd1, 2'd0, "snap_hold");
        pulse_frame(0);
        pix(0, 10'd105, 10'd203, 1'b0, 12'd0, 3'd0, 2'd0, "snap_moved");

        // Illegal type 5 is invisible; metal duck ATT_0 uses frame 3.
        set_slot(0, 0, 3'd0, 3'd0, 10'd0, 10'd0, 1'b0);
        set_slot(0, 3, 3'd5, 3'd1, 10'd10, 10'd10, 1'b0);
        pulse_frame(0);
        pix(0, 10'd10, 10'd10, 1'b0, 12'd0, 3'd0, 2'd0, "type5");
        set_slot(0, 3, 3'd3, 3'd5, 10'd10, 10'd10, 1'b0);
        pulse_frame(0);
        pix(0, 10'd10, 10'd10, 1'b1, 12'd960, 3'd3, 2'd3, "duck_org");
        pix(0, 10'd25, 10'd29, 1'b1, 12'd1279, 3'd3, 2'd3, "duck_last");
        pix(0, 10'd9, 10'd10, 1'b0, 12'd0, 3'd0, 2'd0, "duck_left");

        // Mid-frame reset clears outputs at once and wipes the snapshot.
        pix(0, 10'd10, 10'd10, 1'b1, 12'd960, 3'd3, 2'd3, "pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        check_outs(0, "async_rst", 1'b0, 12'd0, 3'd0, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pix(0, 10'd10, 10'd10, 1'b0, 12'd0, 3'd0, 2'd0, "post_rst");

        // Scaled instance: each texel is a 2x2 block.
        set_slot(1, 0, 3'd1, 3'd1, 10'd100, 10'd200, 1'b0);
        pulse_frame(1);
        pix(1, 10'd111, 10'd207, 1'b1, 12'd53, 3'd1, 2'd0, "scale");
        pix(1, 10'd131, 10'd207, 1'b1, 12'd63, 3'd1, 2'd0, "scale_edge");
        pix(1, 10'd132, 10'd207, 1'b0, 12'd0, 3'd0, 2'd0, "scale_out");
        set_slot(1, 0, 3'd1, 3'd1, 10'd630, 10'd200, 1'b0);
        pulse_frame(1);
        for (int h = 0; h < 10; h++)
            pix(1, 10'(h), 10'd207, 1'b0, 12'd0, 3'd0, 2'd0, "no_wrap");
        pix(1, 10'd639, 10'd207, 1'b1, 12'd52, 3'd1, 2'd0, "clip_right");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/enemy_sprite_addr_gen.md
Name: enemy_sprite_addr_gen

Overview:
- Multi-slot successor to the single-enemy sprite address generator; one instance serves N_SLOTS enemies.
- Each slot holds a type, animation state, position and facing. All slots are captured at frame start so the picture cannot tear.
- For each VGA pixel, a 2-stage pipeline does per-slot hit test, front-slot priority, flip and scale, then produces the per-type sprite ROM address.
- Sits between the enemy controller and the pixel mux.

Parameters:
- N_SLOTS, 4, number of enemy slots; slot 0 is frontmost.
- SLOT_W, 2, width of the slot index; must satisfy 2^SLOT_W >= N_SLOTS.
- ADDR_W, 12, ROM address width.
- SCALE_SHIFT, 0, each sprite texel is drawn as a 2^SCALE_SHIFT square block of screen pixels.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse at the start of each VGA frame
- h_cnt  in  10  current pixel column
- v_cnt  in  10  current pixel row
- slot_type  in  3*N_SLOTS  enemy type per slot: CH_None=0, Killer_Bird=1, White_Bear=2, Metal_Duck=3, Black_Bear=4
- slot_state  in  3*N_SLOTS  animation state per slot: ST_NONE=0, MOVE_0..2=1..3, ATT_CD=4, ATT_0..2=5..7
- slot_x  in  10*N_SLOTS  left edge of sprite on screen
- slot_y  in  10*N_SLOTS  top edge of sprite on screen
- slot_flip  in  N_SLOTS  1 = mirror horizontally
- pix_hit  out  1  some slot covers the pixel
- pix_addr  out  ADDR_W  address in the ROM of the winning slot's type
- pix_type  out  3  type of the winning slot; selects the ROM
- pix_slot  out  SLOT_W  index of the winning slot

Behaviour:
- Always decided: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: every output is 0. Every snapshot register is 0, so all slots read CH_None/ST_NONE and nothing is drawn until the first frame_start.
- Snapshot:
  - On frame_start, all slot_* inputs are registered.
  - Input changes between pulses are ignored.
  - The first pixel pipelined after the pulse already uses the new snapshot.
- Geometry constants (W x H, frame size):
  - Killer_Bird 16x15, 240
  - White_Bear 20x30, 600
  - Metal_Duck 16x20, 320
  - Black_Bear 20x30, 600
- Frame index from state: MOVE_0/1/2 -> 0/1/2; ATT_CD -> 0; ATT_0/1/2 -> 3/4/5. ST_NONE or CH_None means the slot is invisible. Type values 5..7 are also invisible.
- Stage 1 (cycle t+1), per slot:
  - dx = h_cnt - x and dy = v_cnt - y, both computed 11-bit so they cannot wrap.
  - In-box when 0 <= dx < W<<SCALE_SHIFT and 0 <= dy < H<<SCALE_SHIFT, and the slot is visible.
  - col = dx >> SCALE_SHIFT and row = dy >> SCALE_SHIFT.
  - If flipped, col = W-1-col.
  - Register the in-box flag, row, col, frame and type.
- Stage 2 (cycle t+2):
  - The lowest-index in-box slot wins.
  - pix_addr = frame*FRAME_SIZE + row*W + col. Use a constant LUT for the frame base; row*W is a constant multiply per type. No general multiplier.
  - If no slot is in-box: pix_hit=0 and pix_addr, pix_type, pix_slot are all 0.
- Latency: exactly 2 cycles from (h_cnt, v_cnt) to the outputs, every cycle, with no stalls.
- Boundaries:
  - Sprite partly off the right or bottom edge: clipped naturally; no wrap to the left edge.
  - x + width beyond 639 is legal.
  - frame_start together with a pixel: the pixel uses the old snapshot, or the new one if it is registered in the same cycle (the snapshot updates first).
  - rst_n asserted mid-frame: outputs and snapshot clear immediately. The pipeline refills with hit=0.
- The largest address, 3599, fits in 12 bits. ADDR_W < 12 is illegal.

Decomposition:
- Shared package / include holds:
  - the state and type codes
  - per-type W, H and FRAME_SIZE
  - the state-to-frame mapping
- One sub-module: enemy_slot_hit, instantiated N_SLOTS times. It does the stage-1 hit test and row/col/flip for a single snapshot slot.
- The top level holds the snapshot registers, the priority encoder and the stage-2 address build.

Test Plan:
- Reset, then frame_start with all slots CH_None, sweep pixels -> pix_hit=0 and all outputs 0 throughout.
- Slot0 Killer_Bird, MOVE_1, x=100, y=200, no flip, pixel (105,203) -> two cycles later hit=1, type=1, slot=0, addr=1*240+3*16+5=293. Same with flip=1 -> addr=298.
- Slot2 White_Bear, ATT_2, x=300, y=100, pixel (319,129) -> addr=3599. Pixel (320,129) -> hit=0.
- Slot0 bird and slot1 Black_Bear overlapping at pixel (105,203) -> slot=0, type=1. Set slot0 to ST_NONE and pulse frame_start -> slot=1, type=4.
- Change slot0 x from 100 to 200 mid-frame -> outputs unchanged. After the next frame_start, pixel (105,203) -> hit=0.
- SCALE_SHIFT=1, bird at x=100, y=200, pixel (111,207) -> col=5, row=3, addr=48+5=53 (MOVE_0). Bird at x=630 -> pixels at h=0..9 show no hit (no wrap).
